rx_demix: RTL

//  Receive-side counterpart of the transmit mixer. Takes one AD PCM stream, mixes it down against

---
 rtl/rx_demix_pkg.sv | 32 +++
 rtl/rx_demix_mult.sv | 32 +++
 rtl/rx_demix.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rx_demix_pkg.sv
// rx_demix_pkg: shared definitions for the receive-side demixer.
//   state_t     FSM state encoding (IDLE/ISSUE/DRAIN/DUMP)
//   ACC_W       accumulator width for the default decimation
//   DEC_LEN     window length for the default decimation
//   acc_w()     accumulator width for a given decimation shift
//   dec_len()   window length for a given decimation shift
package rx_demix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DUMP  = 2'd3
  } state_t;

  localparam int PCM_W         = 16;
  localparam int PROD_W        = 17;
  localparam int DRAIN_LEN     = 3;
  localparam int DEC_SHIFT_DEF = 6;
  localparam int ACC_W         = PROD_W + DEC_SHIFT_DEF;
  localparam int DEC_LEN       = 1 << DEC_SHIFT_DEF;

  // A full window of 17-bit products never overflows PROD_W + dec_shift bits.
  function automatic int acc_w(input int dec_shift);
    return PROD_W + dec_shift;
  endfunction

  function automatic int dec_len(input int dec_shift);
    return 1 << dec_shift;
  endfunction

endpackage

// File: rtl/rx_demix_mult.sv
// rx_demix_mult: signed multiplier with a configurable output pipeline.
//   clk1, rst   clock, synchronous active-high reset
//   a [di1]     signed operand 1
//   b [di2]     signed operand 2
//   p [dow]     signed product, valid 'pipeline' clocks after a/b
module rx_demix_mult #(
  parameter int di1      = 16,
  parameter int di2      = 16,
  parameter int dow      = 32,
  parameter int pipeline = 2
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic signed [di1-1:0] a,
  input  logic signed [di2-1:0] b,
  output logic signed [dow-1:0] p
);

  logic signed [dow-1:0] stg [pipeline];

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < pipeline; i++) stg[i] <= '0;
    end else begin
      stg[0] <= dow'(a) * dow'(b);
      for (int i = 1; i < pipeline; i++) stg[i] <= stg[i-1];
    end
  end

  assign p = stg[pipeline-1];

endmodule

// File: rtl/rx_demix.sv
// rx_demix: mixes one AD PCM stream down against FREQ_NUM cos/sin carriers,
// integrates-and-dumps over 2^DEC_SHIFT samples, emits per-channel I/Q PCM.
// One shared multiplier is time-multiplexed across all 2*FREQ_NUM products.
//   clk1, rst              clock, synchronous active-high reset
//   ad_pcm_in/valid/ready  sample input handshake (ready only in IDLE)
//   cos_sita, sin_sita     per-channel carriers, ch k at [sita_w*k +: sita_w]
//   ipcm_out, qpcm_out     per-channel results, ch k at [16*k +: 16]
//   iqpcm_valid            1-cycle pulse when results update
//   err_clr, err           sticky overrun/saturation flag and its clear
//
// state | meaning
// IDLE  | waiting for a sample, ready high
// ISSUE | feeding I0,Q0,I1,Q1,... products into the multiplier
// DRAIN | letting the multiplier pipeline and accumulate finish
// DUMP  | round/saturate all accumulators to the outputs, clear window
module rx_demix
  import rx_demix_pkg::*;
#(
  parameter int FREQ_NUM  = 6,
  parameter int sita_w    = 16,
  parameter int DEC_SHIFT = 6
) (
  input  logic                         clk1,
  input  logic                         rst,
  input  logic signed [PCM_W-1:0]      ad_pcm_in,
  input  logic                         ad_pcm_valid,
  output logic                         ad_pcm_ready,
  input  logic [sita_w*FREQ_NUM-1:0]   cos_sita,
  input  logic [sita_w*FREQ_NUM-1:0]   sin_sita,
  output logic [FREQ_NUM*PCM_W-1:0]    ipcm_out,
  output logic [FREQ_NUM*PCM_W-1:0]    qpcm_out,
  output logic                         iqpcm_valid,
  input  logic                         err_clr,
  output logic                         err
);

  localparam int NPROD   = 2 * FREQ_NUM;
  localparam int ACC_WL  = acc_w(DEC_SHIFT);
  localparam int WIN_LEN = dec_len(DEC_SHIFT);
  localparam int CNT_W   = $clog2(NPROD + DRAIN_LEN);
  localparam int IDX_W   = $clog2(NPROD);
  localparam int DOW     = sita_w + PCM_W;

  localparam logic [CNT_W-1:0]     ISSUE_LAST = CNT_W'(NPROD - 1);
  localparam logic [CNT_W-1:0]     DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);
  localparam logic [DEC_SHIFT-1:0] WIN_LAST   = DEC_SHIFT'(WIN_LEN - 1);
  localparam logic signed [ACC_WL:0] HALF    = (ACC_WL+1)'(WIN_LEN / 2);
  localparam logic signed [ACC_WL:0] SAT_MAX = (ACC_WL+1)'(32767);
  localparam logic signed [ACC_WL:0] SAT_MIN = (ACC_WL+1)'(-32768);

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [DEC_SHIFT-1:0]       win_cnt;
  logic signed [PCM_W-1:0]    sample_q;
  logic [sita_w*FREQ_NUM-1:0] cos_q;
  logic [sita_w*FREQ_NUM-1:0] sin_q;
  logic signed [ACC_WL-1:0]   acc [NPROD];
  logic [1:0]                 v_pipe;
  logic [IDX_W-1:0]           idx_pipe [2];

  logic [IDX_W-1:0]           iss_idx;
  logic signed [sita_w-1:0]   car_sel;
  logic signed [DOW-1:0]      prod_full;
  logic signed [PROD_W-1:0]   prod;
  logic                       overrun;

  logic signed [ACC_WL:0]     rnd [NPROD];
  logic signed [ACC_WL:0]     shr [NPROD];
  logic signed [PCM_W-1:0]    dump_val [NPROD];
  logic [NPROD-1:0]           sat_vec;

  assign iss_idx = cnt[IDX_W-1:0];
  assign overrun = ad_pcm_valid && !ad_pcm_ready;

  // Even index = I (cos), odd index = Q (sin) of channel idx/2.
  always_comb begin
    car_sel = '0;
    for (int k = 0; k < FREQ_NUM; k++) begin
      if (int'(iss_idx >> 1) == k)
        car_sel = iss_idx[0] ? sin_q[sita_w*k +: sita_w] : cos_q[sita_w*k +: sita_w];
    end
  end

  rx_demix_mult #(
    .di1      (sita_w),
    .di2      (PCM_W),
    .dow      (DOW),
    .pipeline (2)
  ) u_mult (
    .clk1 (clk1),
    .rst  (rst),
    .a    (car_sel),
    .b    (sample_q),
    .p    (prod_full)
  );

  // Taking the top 17 bits is the arithmetic shift by sita_w-1.
  assign prod = prod_full[DOW-1 -: PROD_W];

  always_comb begin
    for (int k = 0; k < NPROD; k++) begin
      rnd[k]      = $signed({acc[k][ACC_WL-1], acc[k]}) + HALF;
      shr[k]      = rnd[k] >>> DEC_SHIFT;
      sat_vec[k]  = 1'b0;
      dump_val[k] = shr[k][PCM_W-1:0];
      if (shr[k] > SAT_MAX) begin
        dump_val[k] = 16'sh7fff;
        sat_vec[k]  = 1'b1;
      end else if (shr[k] < SAT_MIN) begin
        dump_val[k] = 16'sh8000;
        sat_vec[k]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state        <= ST_IDLE;
      ad_pcm_ready <= 1'b1;
      cnt          <= '0;
      win_cnt      <= '0;
      sample_q     <= '0;
      cos_q        <= '0;
      sin_q        <= '0;
      ipcm_out     <= '0;
      qpcm_out     <= '0;
      iqpcm_valid  <= 1'b0;
      err          <= 1'b0;
      v_pipe       <= '0;
      idx_pipe[0]  <= '0;
      idx_pipe[1]  <= '0;
      for (int k = 0; k < NPROD; k++) acc[k] <= '0;
    end else begin
      iqpcm_valid <= 1'b0;
      // Index/valid pipeline tracks the 2-stage multiplier latency.
      v_pipe      <= {v_pipe[0], state == ST_ISSUE};
      idx_pipe[0] <= iss_idx;
      idx_pipe[1] <= idx_pipe[0];
      if (v_pipe[1])
        acc[idx_pipe[1]] <= acc[idx_pipe[1]] + ACC_WL'(prod);

      if (err_clr)
        err <= 1'b0;
      else if (overrun || (state == ST_DUMP && |sat_vec))
        err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (ad_pcm_valid) begin
            sample_q     <= ad_pcm_in;
            cos_q        <= cos_sita;
            sin_q        <= sin_sita;
            cnt          <= '0;
            ad_pcm_ready <= 1'b0;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cnt == ISSUE_LAST) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt <= '0;
            if (win_cnt == WIN_LAST) begin
              state <= ST_DUMP;
            end else begin
              win_cnt      <= win_cnt + 1'b1;
              ad_pcm_ready <= 1'b1;
              state        <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DUMP: begin
          for (int k = 0; k < FREQ_NUM; k++) begin
            ipcm_out[PCM_W*k +: PCM_W] <= dump_val[2*k];
            qpcm_out[PCM_W*k +: PCM_W] <= dump_val[2*k+1];
          end
          for (int k = 0; k < NPROD; k++) acc[k] <= '0;
          win_cnt      <= '0;
          iqpcm_valid  <= 1'b1;
          ad_pcm_ready <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          ad_pcm_ready <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
